// File: rtl/signal_creater_param.sv
// Serial pattern generator: shifts a stored pattern out LSB first, each bit held div+1 clocks,
// either once or looping until a graceful stop ends the current pattern period.
module signal_creater_param #(
    parameter int   PAT_W    = 16,
    parameter int   LEN_W    = $clog2(PAT_W + 1),
    parameter int   DIV_W    = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic [DIV_W-1:0] div_in,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_idx,
    output logic             state_dbg
);

    // Control semantics: load and start are single-cycle qualifiers sampled on the rising edge
    // and honoured only in IDLE (no ready/back-pressure); when both are high together the
    // freshly loaded values drive that run. stop is latched only while busy.
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             state;
    logic [PAT_W-1:0]   pat;
    logic [LEN_W-1:0]   len;
    logic [DIV_W-1:0]   div;
    logic [PAT_W-1:0]   shreg;
    logic [DIV_W-1:0]   cnt;
    logic               mode_r;
    logic               stop_pend;

    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   eff_len;
    logic [PAT_W-1:0]   eff_pat;
    logic               bit_end;
    logic               last_bit;

    assign state_dbg = state;

    always_comb begin
        len_clamped = (len_in > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len_in;
        eff_len     = load ? len_clamped : len;
        eff_pat     = load ? pattern_in : pat;
        bit_end     = (cnt == div);
        last_bit    = (bit_idx == (len - LEN_W'(1)));
    end

    // shreg[0] always mirrors the bit currently on out, so advancing is a plain shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pat       <= '0;
            len       <= '0;
            div       <= '0;
            shreg     <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            stop_pend <= 1'b0;
            out       <= IDLE_LVL;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    stop_pend <= 1'b0;
                    if (load) begin
                        pat <= pattern_in;
                        len <= len_clamped;
                        div <= div_in;
                    end
                    if (start && (eff_len != '0)) begin
                        state   <= S_RUN;
                        mode_r  <= mode;
                        bit_idx <= '0;
                        cnt     <= '0;
                        shreg   <= eff_pat;
                        out     <= eff_pat[0];
                        busy    <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (!bit_end) begin
                        cnt <= cnt + DIV_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!last_bit) begin
                            bit_idx <= bit_idx + LEN_W'(1);
                            shreg   <= shreg >> 1;
                            out     <= shreg[1];
                        end else if (mode_r && !(stop_pend || stop)) begin
                            bit_idx <= '0;
                            shreg   <= pat;
                            out     <= pat[0];
                        end else begin
                            state     <= S_IDLE;
                            bit_idx   <= '0;
                            out       <= IDLE_LVL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/signal_creater_param.md
# signal_creater_param

Parametrised serial signal generator: shifts out a programmable bit pattern of configurable length on a single output line, each bit stretched by a programmable prescaler. It runs one-shot or as a continuous loop, with a graceful stop and status outputs. It is the generalised successor of the fixed-sequence signal creators in the synchronous sequential circuits collection, and drives test and stimulus lines elsewhere in the design.

## Interface
- PAT_W, 16, maximum pattern length in bits (≥2).
- LEN_W, $clog2(PAT_W+1), width of the length field.
- DIV_W, 8, prescaler width.
- IDLE_LVL, 1'b0, level driven on `out` when not running.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  capture `pattern_in`, `len_in` and `div_in` into config registers; honoured only in IDLE.
- pattern_in  in  PAT_W  bit pattern, sent LSB first.
- len_in  in  LEN_W  number of pattern bits to send.
  - 0 means the config is invalid.
  - Values above PAT_W are clamped to PAT_W at capture.
- div_in  in  DIV_W  each bit is held for div_in+1 clocks.
- mode  in  1  0 = one-shot, 1 = loop; sampled on an accepted start.
- start  in  1  begin a run; honoured only in IDLE with a stored length ≠ 0.
- stop  in  1  loop mode only: finish the current pattern period, then end.
- out  out  1  registered serial output.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse at the end of a run.
- bit_idx  out  LEN_W  index of the bit currently driven on `out`; 0 when idle.

## Operation
- States: IDLE and RUN.
- Config registers `pat`, `len` and `div` reset to 0.
  - Consequence: a start issued before any load is ignored.
- load and start in the same IDLE cycle: the newly loaded values are used for that run.
- IDLE → RUN on an accepted start.
  - The mode register latches `mode`.
  - Bit index and prescaler count clear to 0.
- RUN, bit timing:
  - `out = pat[bit_idx]`.
  - The prescaler counts 0..div.
  - At count == div, bit_idx advances and the prescaler clears.
- RUN, end of the last bit (bit_idx == len-1, count == div):
  - One-shot: go to IDLE; `out` = IDLE_LVL, busy = 0, done = 1 for one cycle.
  - Loop with no stop pending: wrap to bit 0 with no gap cycle; done stays low.
  - Loop with stop pending: behave as one-shot.
- stop handling:
  - stop is latched into a stop-pending flag while in RUN.
  - The flag clears on entering IDLE.
  - stop in IDLE is ignored.
- Ignored inputs:
  - start while busy.
  - load while busy; config stays stable during a run.
- Reset mid-run takes effect immediately and asynchronously:
  - out = IDLE_LVL, busy = 0, done = 0, bit_idx = 0.
  - State = IDLE; config registers and the stop-pending flag clear.

## Timing
- Reset values: out = IDLE_LVL, busy = 0, done = 0, bit_idx = 0.
- Start sampled at edge k: `out` = pat[0] and busy = 1 from cycle k+1.
- One-shot run:
  - Bit i is driven during cycles k+1+i·(div+1) through k+(i+1)·(div+1).
  - done = 1, busy = 0 and `out` = IDLE_LVL at cycle k+1+len·(div+1).
- The earliest new start is accepted in the same cycle done is high, i.e. the cycle IDLE is entered.
- Loop period is exactly len·(div+1) cycles, with no idle cycle at the wrap.
- len = 1 with div = 0: one-shot produces a single-cycle pulse of pat[0].

## Test plan
- Reset and idle:
  - Hold rst = 0, then release -> out = 0, busy = 0, done = 0, bit_idx = 0.
  - start with no prior load -> busy stays 0.
- One-shot, no prescale:
  - load pattern 8'hA5, len 8, div 0; start at edge 0.
  - -> out = 1,0,1,0,0,1,0,1 in cycles 1-8.
  - -> done = 1 and busy = 0 in cycle 9; done = 0 in cycle 10.
- Prescale:
  - Same pattern with div 2 -> each bit held 3 cycles; done in cycle 25.
- Loop and stop:
  - pattern 4'b0011, len 4, div 0, mode 1 -> out repeats 1,1,0,0 with no gap.
  - Pulse stop during bit 1 of the third period -> that period completes, then done; out = 0 afterwards.
- Boundaries:
  - len_in = 31 with PAT_W = 16 -> 16 bits sent.
  - load with len 0, then start -> ignored.
  - start and load issued while busy -> no effect on the current run.
- Async reset mid-run:
  - Assert rst low between edges during bit 3 -> out = 0 and busy = 0 immediately.
  - After release, start without a new load -> ignored, since config was cleared.
